fetch: RTL and testbench

FETCH -- requirements
Module: fetch

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_next_pc_mux.sv | 28 ++
 rtl/fetch.sv | 40 ++++
 tb/tb_fetch.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared processor constants and types for the instruction-fetch stage.
// Module parameters default from here so one edit retargets the whole core.
package fetch_pkg;

   localparam int unsigned DEFAULT_ADDRESS_BITS = 16;
   localparam int unsigned DEFAULT_PC_STEP      = 4;
   localparam int unsigned DEFAULT_RESET_PC     = 0;

   typedef enum logic {
      PC_SEL_SEQ    = 1'b0,
      PC_SEL_TARGET = 1'b1
   } pc_sel_e;

endpackage

// File: rtl/fetch_next_pc_mux.sv
// Combinational next-PC selection: either the sequential address or the
// branch/jump target. The add wraps modulo 2^ADDRESS_BITS with no carry out.
module next_pc_mux
   import fetch_pkg::*;
#(
   parameter int unsigned ADDRESS_BITS = DEFAULT_ADDRESS_BITS,
   parameter int unsigned PC_STEP      = DEFAULT_PC_STEP
) (
   input  logic [ADDRESS_BITS-1:0] PC,
   input  logic [ADDRESS_BITS-1:0] target_PC,
   input  logic                    next_PC_select,
   output logic [ADDRESS_BITS-1:0] next_PC
);

   logic [ADDRESS_BITS-1:0] seq_PC;
   pc_sel_e                 sel;

   always_comb begin
      seq_PC  = PC + ADDRESS_BITS'(PC_STEP);
      sel     = pc_sel_e'(next_PC_select);
      next_PC = seq_PC;
      if (sel == PC_SEL_TARGET) begin
         // Target taken verbatim; unaligned destinations are deliberately kept.
         next_PC = target_PC;
      end
   end

endmodule

// File: rtl/fetch.sv
// Instruction-fetch program counter: one register advanced every cycle,
// asynchronously forced to RESET_PC while reset is high.
module fetch
   import fetch_pkg::*;
#(
   parameter int unsigned ADDRESS_BITS = DEFAULT_ADDRESS_BITS,
   parameter int unsigned PC_STEP      = DEFAULT_PC_STEP,
   parameter int unsigned RESET_PC     = DEFAULT_RESET_PC
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    next_PC_select,
   input  logic [ADDRESS_BITS-1:0] target_PC,
   output logic [ADDRESS_BITS-1:0] PC
);

   logic [ADDRESS_BITS-1:0] pc_q;
   logic [ADDRESS_BITS-1:0] next_PC;

   next_pc_mux #(
      .ADDRESS_BITS (ADDRESS_BITS),
      .PC_STEP      (PC_STEP)
   ) u_next_pc_mux (
      .PC             (pc_q),
      .target_PC      (target_PC),
      .next_PC_select (next_PC_select),
      .next_PC        (next_PC)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pc_q <= ADDRESS_BITS'(RESET_PC);
      end else begin
         pc_q <= next_PC;
      end
   end

   assign PC = pc_q;

endmodule

// File: tb/tb_fetch.sv
// Scoreboard bench for fetch: stimulus pushes hand-computed PC values,
// a monitor pops and compares after each clock edge or asynchronous probe.
module tb_fetch;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        next_PC_select = 1'b0;
   logic [15:0] target_PC = '0;
   logic [15:0] PC;

   typedef struct {
      string       name;
      logic [15:0] exp;
   } exp_t;

   exp_t q[$];
   int   checks   = 0;
   int   failures = 0;
   event async_ev;

   fetch #(
      .ADDRESS_BITS (16),
      .PC_STEP      (4),
      .RESET_PC     (0)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .next_PC_select (next_PC_select),
      .target_PC      (target_PC),
      .PC             (PC)
   );

   always #5 clock = ~clock;

   // Monitor: one pop per edge or asynchronous probe, only when something is expected.
   initial begin
      exp_t e;
      forever begin
         @(posedge clock or async_ev);
         #1;
         if (q.size() != 0) begin
            e = q.pop_front();
            checks++;
            if (PC !== e.exp) begin
               failures++;
               $display("FAIL %s: PC=%h expected %h", e.name, PC, e.exp);
            end
         end
      end
   end

   task automatic push(input string name, input logic [15:0] exp);
      exp_t e;
      e.name = name;
      e.exp  = exp;
      q.push_back(e);
   endtask

   // Drive inputs at the falling edge; expectation is PC after the next rising edge.
   task automatic step(input string name, input logic rst, input logic sel,
                       input logic [15:0] tgt, input logic [15:0] exp);
      @(negedge clock);
      reset          = rst;
      next_PC_select = sel;
      target_PC      = tgt;
      push(name, exp);
   endtask

   // Probe PC between edges, away from any clock edge.
   task automatic probe(input string name, input logic [15:0] exp);
      push(name, exp);
      -> async_ev;
      #2;
   endtask

   initial begin
      reset = 1'b1;
      #2;
      probe("reset_immediate", 16'h0000);

      step("reset_hold0", 1'b1, 1'b0, 16'h0000, 16'h0000);
      step("reset_hold1", 1'b1, 1'b0, 16'h0000, 16'h0000);
      step("seq_0004",    1'b0, 1'b0, 16'h0000, 16'h0004);
      step("seq_0008",    1'b0, 1'b0, 16'h0000, 16'h0008);
      step("seq_000C",    1'b0, 1'b0, 16'h0000, 16'h000C);

      @(negedge clock);
      #2;
      reset = 1'b1;
      probe("midcycle_reset", 16'h0000);
      step("midreset_hold", 1'b1, 1'b0, 16'h0000, 16'h0000);
      step("after_rst_0004", 1'b0, 1'b0, 16'h0000, 16'h0004);
      step("after_rst_0008", 1'b0, 1'b0, 16'h0000, 16'h0008);

      step("target_0010a", 1'b0, 1'b1, 16'h0010, 16'h0010);
      step("target_0010b", 1'b0, 1'b1, 16'h0010, 16'h0010);
      step("seq_0014",     1'b0, 1'b0, 16'h0000, 16'h0014);
      step("seq_0018",     1'b0, 1'b0, 16'h0000, 16'h0018);

      // Mid-cycle input glitch must not reach PC before or at the edge.
      @(negedge clock);
      next_PC_select = 1'b1;
      target_PC      = 16'hABCD;
      #2;
      probe("no_comb_path", 16'h0018);
      next_PC_select = 1'b0;
      target_PC      = 16'h0000;
      push("glitch_ignored", 16'h001C);

      step("target_FFFC", 1'b0, 1'b1, 16'hFFFC, 16'hFFFC);
      step("wrap_0000",   1'b0, 1'b0, 16'h0000, 16'h0000);
      step("wrap_0004",   1'b0, 1'b0, 16'h0000, 16'h0004);

      @(negedge clock);
      next_PC_select = 1'b1;
      target_PC      = 16'h1234;
      reset          = 1'b1;
      #2;
      probe("rst_over_sel", 16'h0000);
      push("rst_prio_edge0", 16'h0000);
      step("rst_prio_edge1", 1'b1, 1'b1, 16'h1234, 16'h0000);
      step("target_1234",    1'b0, 1'b1, 16'h1234, 16'h1234);

      step("unaligned_0013", 1'b0, 1'b1, 16'h0013, 16'h0013);
      step("unaligned_0017", 1'b0, 1'b0, 16'h0000, 16'h0017);

      repeat (3) @(negedge clock);
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: pending=%0d expected 0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      $fatal(1, "timeout");
   end

endmodule
